// File: rtl/line_rasterizer_if.sv
// line_rasterizer_if: segment pop bus from the clipper plus pixel write bus
// to the frame-buffer writer, bundled for the Bresenham rasterizer.
//   slave  : rasterizer side (takes segments, emits pixels)
//   master : environment side (clipper + frame-buffer writer)
// Signals:
//   x0_in/y0_in/x1_in/y1_in/color_in/vld : segment delivered by the clipper
//   end_of_obj                           : last segment of the object sent
//   raster_ready                         : clipper may pop one segment
//   pix_x/pix_y/pix_color/pix_we         : pixel write, taken when fb_ready
//   busy / obj_done                      : status
interface line_rasterizer_if;
  logic [9:0] x0_in, y0_in, x1_in, y1_in;
  logic [2:0] color_in;
  logic       vld;
  logic       end_of_obj;
  logic       raster_ready;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_color;
  logic       pix_we;
  logic       fb_ready;
  logic       busy;
  logic       obj_done;

  modport master (
    output x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, fb_ready,
    input  raster_ready, pix_x, pix_y, pix_color, pix_we, busy, obj_done
  );

  modport slave (
    input  x0_in, y0_in, x1_in, y1_in, color_in, vld, end_of_obj, fb_ready,
    output raster_ready, pix_x, pix_y, pix_color, pix_we, busy, obj_done
  );
endinterface

// File: rtl/line_rasterizer.sv
// line_rasterizer: queues clipped line segments and walks each one with
// Bresenham, one pixel per cycle, stalling on fb_ready. Forwards the
// clipper's end-of-object marker as obj_done once everything is drawn.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : line_rasterizer_if.slave (segment input, pixel output, status)
// Parameter:
//   QDEPTH     : line-queue entries (power of two, >= 2)
module line_rasterizer #(
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  line_rasterizer_if.slave   bus
);
  localparam int          AW     = $clog2(QDEPTH);
  localparam logic [AW:0] QFULL  = (AW+1)'(QDEPTH);
  localparam logic [AW:0] RR_MAX = (AW+1)'(QDEPTH - 2);

  typedef struct packed {
    logic [9:0] x0, y0, x1, y1;
    logic [2:0] color;
  } seg_t;

  typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

  seg_t               mem_q [QDEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  logic [2:0]         col_q, col_d;
  logic signed [12:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic               sx_q, sx_d, sy_q, sy_d;
  logic               eoo_pend_q, eoo_pend_d;

  logic               wr_en, pop, accept, at_end, step_x, step_y, obj_done;
  logic signed [12:0] e2, ddx, ddy;
  seg_t               head, seg_in;

  assign seg_in = '{bus.x0_in, bus.y0_in, bus.x1_in, bus.y1_in, bus.color_in};
  assign head   = mem_q[rd_ptr_q];

  // A vld while full is dropped outright; raster_ready prevents it normally.
  assign wr_en  = bus.vld && (count_q != QFULL);
  // Pop decision uses the registered count, so it can never underflow.
  assign pop    = (state_q == IDLE) && (count_q != '0);
  assign accept = (state_q == DRAW) && bus.fb_ready;
  assign at_end = (x_q == x1_q) && (y_q == y1_q);

  // In SETUP, x_q/y_q still hold the start point loaded at pop.
  assign ddx    = $signed({3'b000, x1_q}) - $signed({3'b000, x_q});
  assign ddy    = $signed({3'b000, y1_q}) - $signed({3'b000, y_q});
  assign e2     = err_q <<< 1;
  assign step_x = (e2 >= dy_q);
  assign step_y = (e2 <= dx_q);

  // All queued work drawn and nothing arriving this cycle.
  assign obj_done = eoo_pend_q && (count_q == '0) && (state_q == IDLE) && !bus.vld;

  always_comb begin
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    eoo_pend_d = obj_done ? 1'b0 : (eoo_pend_q | bus.end_of_obj);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    col_d   = col_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          x_d     = head.x0;
          y_d     = head.y0;
          x1_d    = head.x1;
          y1_d    = head.y1;
          col_d   = head.color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d    = (ddx < 0) ? -ddx : ddx;
        dy_d    = (ddy < 0) ? ddy : -ddy;
        sx_d    = (x_q < x1_q);
        sy_d    = (y_q < y1_q);
        err_d   = dx_d + dy_d;
        state_d = DRAW;
      end
      DRAW: begin
        if (accept) begin
          if (at_end) begin
            state_d = IDLE;
          end else begin
            // Both steps read the pre-update err.
            if (step_x) x_d = sx_q ? x_q + 10'd1 : x_q - 10'd1;
            if (step_y) y_d = sy_q ? y_q + 10'd1 : y_q - 10'd1;
            err_d = err_q + (step_x ? dy_q : 13'sd0) + (step_y ? dx_q : 13'sd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= seg_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      col_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      err_q      <= '0;
      sx_q       <= 1'b0;
      sy_q       <= 1'b0;
      eoo_pend_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      col_q      <= col_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      err_q      <= err_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      eoo_pend_q <= eoo_pend_d;
    end
  end

  assign bus.raster_ready = (count_q <= RR_MAX);
  assign bus.pix_x        = x_q;
  assign bus.pix_y        = y_q;
  assign bus.pix_color    = col_q;
  assign bus.pix_we       = (state_q == DRAW);
  assign bus.busy         = (count_q != '0) || (state_q != IDLE);
  assign bus.obj_done     = obj_done;
endmodule

// File: tb/tb_line_rasterizer.sv
module tb_line_rasterizer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_rasterizer_if bus ();

  line_rasterizer #(.QDEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed { int x0, y0, x1, y1, col, first, n; } vec_t;
  typedef struct packed { logic [9:0] x0, y0, x1, y1; logic [2:0] c; } seg_t;

  // Hand-computed Bresenham pixel lists, concatenated in table order.
  int exp_x [24] = '{0,1,2,3, 0,0,1,1, 5,4,3,2, 7, 10,9,8,7,6,5,4, 2,2,2,2};
  int exp_y [24] = '{0,0,0,0, 0,1,2,3, 5,6,7,8, 9, 3,3,2,2,2,1,1, 4,3,2,1};

  vec_t        vec [6];
  seg_t        send_q [$];
  logic [22:0] got_q [$];

  int   checks = 0, errors = 0;
  int   cyc = 0, sent = 0;
  int   vld_cyc = 0, first_cyc = -1, last_acc_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic rr_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Clipper model: pops one cycle after seeing raster_ready.
  initial begin
    seg_t s;
    bus.vld = 1'b0;
    bus.x0_in = '0; bus.y0_in = '0; bus.x1_in = '0; bus.y1_in = '0; bus.color_in = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && rr_seen && send_q.size() > 0) begin
        s = send_q.pop_front();
        bus.x0_in = s.x0; bus.y0_in = s.y0; bus.x1_in = s.x1; bus.y1_in = s.y1;
        bus.color_in = s.c;
        bus.vld = 1'b1;
        vld_cyc = cyc;
        sent++;
      end else begin
        bus.vld = 1'b0;
      end
    end
  end

  // Monitor, sampling mid-cycle.
  initial forever begin
    @(negedge clk);
    rr_seen = bus.raster_ready && rst_n;
    if (rst_n) begin
      if (bus.pix_we && first_cyc < 0) first_cyc = cyc;
      if (bus.pix_we && bus.fb_ready) begin
        got_q.push_back({bus.pix_x, bus.pix_y, bus.pix_color});
        last_acc_cyc = cyc;
      end
      if (bus.obj_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(vec_t v);
    send_q.push_back({10'(v.x0), 10'(v.y0), 10'(v.x1), 10'(v.y1), 3'(v.col)});
  endtask

  task automatic wait_done(string nm, int n, int lim);
    int t = 0;
    while ((send_q.size() > 0 || got_q.size() < n || bus.busy) && t < lim) begin
      tick();
      t++;
    end
    checks++;
    if (t >= lim) begin
      errors++;
      $display("FAIL %s: timeout with %0d pixels, expected %0d", nm, got_q.size(), n);
    end
  endtask

  task automatic wait_pix(string nm, int n, int lim);
    int t = 0;
    while (got_q.size() < n && t < lim) begin
      tick();
      t++;
    end
    checks++;
    if (t >= lim) begin
      errors++;
      $display("FAIL %s: timeout with %0d pixels, expected %0d", nm, got_q.size(), n);
    end
  endtask

  task automatic check_seg(int i, int base);
    for (int k = 0; k < vec[i].n; k++) begin
      logic [22:0] e;
      logic [22:0] a;
      e = {10'(exp_x[vec[i].first + k]), 10'(exp_y[vec[i].first + k]), 3'(vec[i].col)};
      a = (base + k < got_q.size()) ? got_q[base + k] : 'x;
      chk($sformatf("seg%0d_pix%0d", i, k), 32'(a), 32'(e));
    end
  endtask

  vec_t long_v;
  int   base, eoo_cyc;

  initial begin
    vec[0] = '{0, 0, 3, 0, 5,  0, 4};   // horizontal
    vec[1] = '{0, 0, 1, 3, 1,  4, 4};   // steep
    vec[2] = '{5, 5, 2, 8, 2,  8, 4};   // reverse x
    vec[3] = '{7, 9, 7, 9, 7, 12, 1};   // point
    vec[4] = '{10, 3, 4, 1, 3, 13, 7};  // shallow, both negative
    vec[5] = '{2, 4, 2, 1, 6, 20, 4};   // vertical upward
    long_v = '{0, 0, 9, 0, 4, 0, 10};

    rst_n = 1'b0;
    bus.fb_ready = 1'b1;
    bus.end_of_obj = 1'b0;
    repeat (3) tick();
    chk("rst_raster_ready", 32'(bus.raster_ready), 32'd1);
    chk("rst_pix_we",       32'(bus.pix_we),       32'd0);
    chk("rst_pix_x",        32'(bus.pix_x),        32'd0);
    chk("rst_pix_y",        32'(bus.pix_y),        32'd0);
    chk("rst_pix_color",    32'(bus.pix_color),    32'd0);
    chk("rst_busy",         32'(bus.busy),         32'd0);
    chk("rst_obj_done",     32'(bus.obj_done),     32'd0);
    rst_n = 1'b1;
    tick();

    // Table: one segment at a time, full pixel list and latency.
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      first_cyc = -1;
      send(vec[i]);
      wait_done($sformatf("seg%0d_done", i), vec[i].n, 100);
      chk($sformatf("seg%0d_count", i), 32'(got_q.size()), 32'(vec[i].n));
      check_seg(i, 0);
      chk($sformatf("seg%0d_latency", i), 32'(first_cyc - vld_cyc), 32'd3);
      repeat (2) tick();
      chk($sformatf("seg%0d_no_extra", i), 32'(got_q.size()), 32'(vec[i].n));
    end
    chk("no_spurious_obj_done", 32'(done_cnt), 32'd0);

    // end_of_obj during a line: obj_done one cycle after the last accept.
    got_q.delete();
    done_cnt = 0;
    base = sent;
    send(vec[0]);
    for (int t = 0; t < 20 && sent == base; t++) tick();
    tick();
    bus.end_of_obj = 1'b1;
    tick();
    bus.end_of_obj = 1'b0;
    wait_done("eoo_line_done", 4, 100);
    repeat (3) tick();
    chk("eoo_line_pulses", 32'(done_cnt), 32'd1);
    chk("eoo_line_timing", 32'(done_cyc - last_acc_cyc), 32'd1);

    // end_of_obj while idle and empty: obj_done the following cycle.
    done_cnt = 0;
    bus.end_of_obj = 1'b1;
    eoo_cyc = cyc;
    tick();
    bus.end_of_obj = 1'b0;
    repeat (3) tick();
    chk("eoo_idle_pulses", 32'(done_cnt), 32'd1);
    chk("eoo_idle_timing", 32'(done_cyc - eoo_cyc), 32'd1);

    // Two end_of_obj pulses while pending give a single obj_done.
    got_q.delete();
    done_cnt = 0;
    base = sent;
    send(vec[5]);
    for (int t = 0; t < 20 && sent == base; t++) tick();
    tick();
    bus.end_of_obj = 1'b1; tick(); bus.end_of_obj = 1'b0; tick();
    bus.end_of_obj = 1'b1; tick(); bus.end_of_obj = 1'b0;
    wait_done("eoo_twice_done", 4, 100);
    repeat (4) tick();
    chk("eoo_twice_pulses", 32'(done_cnt), 32'd1);

    // Backpressure: hold fb_ready low for 5 cycles mid-line.
    got_q.delete();
    send(long_v);
    wait_pix("bp_reach3", 3, 100);
    bus.fb_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_pix_x",  32'(bus.pix_x),  32'd3);
      chk("bp_pix_y",  32'(bus.pix_y),  32'd0);
      chk("bp_pix_we", 32'(bus.pix_we), 32'd1);
    end
    chk("bp_held_count", 32'(got_q.size()), 32'd3);
    tick();
    bus.fb_ready = 1'b1;
    wait_done("bp_done", 10, 100);
    chk("bp_count", 32'(got_q.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      logic [22:0] a;
      a = (k < got_q.size()) ? got_q[k] : 'x;
      chk($sformatf("bp_pix%0d", k), 32'(a), 32'({10'(k), 10'd0, 3'd4}));
    end

    // Burst of 6 with fb_ready low: 1 in the working set, 4 queued, 1 held back.
    got_q.delete();
    bus.fb_ready = 1'b0;
    base = sent;
    for (int i = 0; i < 6; i++) send(vec[i]);
    repeat (20) tick();
    chk("burst_sent_stalled", 32'(sent - base), 32'd5);
    chk("burst_raster_ready", 32'(bus.raster_ready), 32'd0);
    chk("burst_no_pixels",    32'(got_q.size()), 32'd0);
    bus.fb_ready = 1'b1;
    wait_done("burst_done", 24, 400);
    chk("burst_sent_all", 32'(sent - base), 32'd6);
    chk("burst_count",    32'(got_q.size()), 32'd24);
    for (int i = 0; i < 6; i++) check_seg(i, vec[i].first);

    // Reset in the middle of a 10-pixel line.
    got_q.delete();
    send(long_v);
    wait_pix("rst_reach3", 3, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_pix_we", 32'(bus.pix_we), 32'd0);
    chk("midrst_busy",   32'(bus.busy),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
    tick();
    chk("postrst_raster_ready", 32'(bus.raster_ready), 32'd1);
    chk("postrst_busy",         32'(bus.busy),         32'd0);
    repeat (15) tick();
    chk("postrst_no_pixels", 32'(got_q.size()), 32'd0);
    chk("postrst_pix_we",    32'(bus.pix_we),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
